// File: rtl/pe_pkg.sv
// Shared types and helpers for the multi-lane rate-coded inner-product PE.
// Window FSM states, product mode selectors and a width-generic saturating adder.
package pe_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } pe_state_e;

   localparam int MODE_UNI = 0;
   localparam int MODE_BI  = 1;

   // Operands arrive sign-extended to 64 bits; the result is clamped to a w-bit signed range.
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int w);
      logic signed [64:0] s, hi, lo;
      s  = 65'(a) + 65'(b);
      hi = (65'sd1 <<< (w - 1)) - 65'sd1;
      lo = -(65'sd1 <<< (w - 1));
      if (s > hi) return 64'(hi);
      if (s < lo) return 64'(lo);
      return 64'(s);
   endfunction

endpackage

// File: rtl/pe_lane.sv
// One stochastic multiply lane: weight register, bitstream comparator and signed +/-1/0 contribution.
module pe_lane
   import pe_pkg::*;
#(
   parameter int IWIDTH = 16,
   parameter int MODE   = MODE_UNI
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_w_i,
   input  logic              clr_w_i,
   input  logic [IWIDTH-1:0] wght_i,
   input  logic              ifm_bit_i,
   input  logic              ifm_sign_i,
   input  logic [IWIDTH-2:0] randw_i,
   output logic [IWIDTH-1:0] wght_o,
   output logic signed [1:0] contrib_o
);

   logic [IWIDTH-1:0] w_q;
   logic              wbit, p, neg;

   always_ff @(posedge clk) begin
      if (rst)          w_q <= '0;
      else if (clr_w_i) w_q <= '0;
      else if (en_w_i)  w_q <= wght_i;
   end

   // Magnitude drives the bitstream in both modes; the sign only matters for bipolar.
   assign wbit = (randw_i < w_q[IWIDTH-2:0]);
   assign p    = ifm_bit_i & wbit;
   assign neg  = (MODE == MODE_BI) && (ifm_sign_i ^ w_q[IWIDTH-1]);

   always_comb begin
      contrib_o = 2'sb00;
      if (p) contrib_o = neg ? 2'sb11 : 2'sb01;
   end

   assign wght_o = w_q;

endmodule

// File: rtl/pe_inner_mc.sv
// Multi-lane rate-coded inner-product PE: per-lane stochastic products summed into a windowed,
// saturating accumulator that is added to the upstream partial sum and forwarded systolically.
module pe_inner_mc
   import pe_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int IWIDTH = 16,
   parameter int OWIDTH = 24,
   parameter int CWIDTH = 16,
   parameter int MODE   = MODE_UNI
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [CWIDTH-1:0]       cfg_len,
   input  logic                    en_w,
   input  logic                    clr_w,
   input  logic                    en_o,
   input  logic                    clr_o,
   input  logic [LANES-1:0]        ifm_bit,
   input  logic [LANES-1:0]        ifm_sign,
   input  logic [LANES*IWIDTH-1:0] wght,
   input  logic [IWIDTH-2:0]       randW,
   input  logic [OWIDTH-1:0]       ofm,
   output logic                    en_w_d,
   output logic                    clr_w_d,
   output logic                    en_o_d,
   output logic                    clr_o_d,
   output logic [LANES-1:0]        ifm_bit_d,
   output logic [LANES-1:0]        ifm_sign_d,
   output logic [LANES*IWIDTH-1:0] wght_d,
   output logic [IWIDTH-2:0]       randW_d,
   output logic [OWIDTH-1:0]       ofm_d,
   output logic                    mac_done_d,
   output logic                    busy
);

   localparam int DW = $clog2(LANES + 1) + 1;

   logic                    en_w_q, clr_w_q, en_o_q, clr_o_q;
   logic [LANES-1:0]        ifm_bit_q, ifm_sign_q;
   logic [IWIDTH-2:0]       randw_q;
   logic [LANES*IWIDTH-1:0] wght_q;
   logic [LANES-1:0][1:0]   contrib;

   pe_state_e               state_q;
   logic [CWIDTH-1:0]       cnt_q;
   logic signed [OWIDTH-1:0] acc_q, acc_d;
   logic [OWIDTH-1:0]       ofm_q, ofm_sum_d;
   logic                    done_q;
   logic signed [DW-1:0]    delta;
   logic                    launch;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      pe_lane #(.IWIDTH(IWIDTH), .MODE(MODE)) u_lane (
         .clk       (clk),
         .rst       (rst),
         .en_w_i    (en_w),
         .clr_w_i   (clr_w),
         .wght_i    (wght[i*IWIDTH +: IWIDTH]),
         .ifm_bit_i (ifm_bit_q[i]),
         .ifm_sign_i(ifm_sign_q[i]),
         .randw_i   (randW),
         .wght_o    (wght_q[i*IWIDTH +: IWIDTH]),
         .contrib_o (contrib[i])
      );
   end

   always_comb begin
      delta = '0;
      for (int i = 0; i < LANES; i++) delta = delta + DW'($signed(contrib[i]));
   end

   assign acc_d     = OWIDTH'(sat_add(64'(acc_q), 64'(delta), OWIDTH));
   assign ofm_sum_d = OWIDTH'(sat_add(64'($signed(ofm)), 64'(acc_q), OWIDTH));
   assign launch    = start && (cfg_len != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         en_w_q     <= 1'b0;
         clr_w_q    <= 1'b0;
         en_o_q     <= 1'b0;
         clr_o_q    <= 1'b0;
         ifm_bit_q  <= '0;
         ifm_sign_q <= '0;
         randw_q    <= '0;
      end else begin
         en_w_q     <= en_w;
         clr_w_q    <= clr_w;
         en_o_q     <= en_o;
         clr_o_q    <= clr_o;
         ifm_bit_q  <= ifm_bit;
         ifm_sign_q <= ifm_sign;
         randw_q    <= randW;
      end
   end

   // Window FSM; ofm_d passes ofm through except in the single DONE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         ofm_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         ofm_q  <= ofm;
         if (clr_o) begin
            acc_q   <= '0;
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: if (launch) begin
                  cnt_q   <= cfg_len - CWIDTH'(1);
                  state_q <= RUN;
               end
               RUN: if (en_o) begin
                  acc_q <= acc_d;
                  if (cnt_q == '0) state_q <= DONE;
                  else             cnt_q   <= cnt_q - CWIDTH'(1);
               end
               DONE: begin
                  ofm_q  <= ofm_sum_d;
                  done_q <= 1'b1;
                  acc_q  <= '0;
                  if (launch) begin
                     cnt_q   <= cfg_len - CWIDTH'(1);
                     state_q <= RUN;
                  end else begin
                     state_q <= IDLE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign en_w_d     = en_w_q;
   assign clr_w_d    = clr_w_q;
   assign en_o_d     = en_o_q;
   assign clr_o_d    = clr_o_q;
   assign ifm_bit_d  = ifm_bit_q;
   assign ifm_sign_d = ifm_sign_q;
   assign wght_d     = wght_q;
   assign randW_d    = randw_q;
   assign ofm_d      = ofm_q;
   assign mac_done_d = done_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_pe_inner_mc.sv
// Directed bench: unipolar and bipolar PEs share stimulus; expected window results are queued at
// start and compared, including arrival cycle, when mac_done_d fires.
module tb_pe_inner_mc;

   localparam int L = 4, IW = 16, OW = 24, CW = 16;

   logic clk = 1'b0;
   logic rst, start, en_w, clr_w, en_o, clr_o;
   logic [CW-1:0]   cfg_len;
   logic [L-1:0]    ifm_bit, ifm_sign;
   logic [L*IW-1:0] wght;
   logic [IW-2:0]   randW;
   logic [OW-1:0]   ofm;

   logic en_w_d0, clr_w_d0, en_o_d0, clr_o_d0, done0, busy0;
   logic en_w_d1, clr_w_d1, en_o_d1, clr_o_d1, done1, busy1;
   logic [L-1:0]    ifm_bit_d0, ifm_sign_d0, ifm_bit_d1, ifm_sign_d1;
   logic [L*IW-1:0] wght_d0, wght_d1;
   logic [IW-2:0]   randW_d0, randW_d1;
   logic [OW-1:0]   ofm_d0, ofm_d1;

   typedef struct {
      logic [OW-1:0] o0;
      logic [OW-1:0] o1;
      int            due;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pe_inner_mc #(.LANES(L), .IWIDTH(IW), .OWIDTH(OW), .CWIDTH(CW), .MODE(0)) u0 (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .en_w(en_w), .clr_w(clr_w),
      .en_o(en_o), .clr_o(clr_o), .ifm_bit(ifm_bit), .ifm_sign(ifm_sign), .wght(wght),
      .randW(randW), .ofm(ofm), .en_w_d(en_w_d0), .clr_w_d(clr_w_d0), .en_o_d(en_o_d0),
      .clr_o_d(clr_o_d0), .ifm_bit_d(ifm_bit_d0), .ifm_sign_d(ifm_sign_d0), .wght_d(wght_d0),
      .randW_d(randW_d0), .ofm_d(ofm_d0), .mac_done_d(done0), .busy(busy0));

   pe_inner_mc #(.LANES(L), .IWIDTH(IW), .OWIDTH(OW), .CWIDTH(CW), .MODE(1)) u1 (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .en_w(en_w), .clr_w(clr_w),
      .en_o(en_o), .clr_o(clr_o), .ifm_bit(ifm_bit), .ifm_sign(ifm_sign), .wght(wght),
      .randW(randW), .ofm(ofm), .en_w_d(en_w_d1), .clr_w_d(clr_w_d1), .en_o_d(en_o_d1),
      .clr_o_d(clr_o_d1), .ifm_bit_d(ifm_bit_d1), .ifm_sign_d(ifm_sign_d1), .wght_d(wght_d1),
      .randW_d(randW_d1), .ofm_d(ofm_d1), .mac_done_d(done1), .busy(busy1));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load_w(input logic [L*IW-1:0] w);
      wght = w; en_w = 1'b1; tick(); en_w = 1'b0;
      chk("wght_load", wght_d0, w);
   endtask

   // Request a window; the result is due len+2 posedges after this drive point (plus stalls).
   task automatic kick(input int len, input logic [OW-1:0] e0, input logic [OW-1:0] e1, input int extra);
      exp_t e;
      e.o0 = e0; e.o1 = e1; e.due = cyc + len + 2 + extra;
      sb.push_back(e);
      cfg_len = CW'(len); start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      exp_t e;
      int   n = 0;
      while (!done0 && n < 200) begin tick(); n++; end
      chk({tag, "_seen"}, 64'(done0), 64'd1);
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_cycle"}, 64'(cyc), 64'(e.due));
         chk({tag, "_uni"}, 64'(ofm_d0), 64'(e.o0));
         chk({tag, "_bi"}, 64'(ofm_d1), 64'(e.o1));
         chk({tag, "_bi_done"}, 64'(done1), 64'd1);
      end
      tick();
      chk({tag, "_pulse"}, 64'({done0, done1}), 64'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; cfg_len = '0; en_w = 1'b1; clr_w = 1'b0; en_o = 1'b1;
      clr_o = 1'b0; ifm_bit = '1; ifm_sign = '1; wght = '1; randW = '0; ofm = 24'd5;
      tick(); tick();
      chk("rst_ofm_d", 64'(ofm_d0), 64'd0);
      chk("rst_wght_d", wght_d1, 64'd0);
      chk("rst_flags", 64'({done0, busy0, en_w_d0, en_o_d1, ifm_bit_d0}), 64'd0);
      rst = 1'b0; en_w = 1'b0; ifm_bit = '0; ifm_sign = '0; wght = '0;

      // forwarding path
      ifm_bit = 4'hA; ifm_sign = 4'h5; randW = 15'h1234; ofm = 24'h00ABCD; clr_w = 1'b1;
      tick();
      chk("fwd_ifm", 64'({ifm_bit_d0, ifm_sign_d1}), 64'hA5);
      chk("fwd_rand", 64'(randW_d0), 64'h1234);
      chk("fwd_ofm", 64'(ofm_d1), 64'h00ABCD);
      chk("fwd_ctl", 64'({en_w_d0, clr_w_d0, en_o_d0, clr_o_d0}), 64'b0110);
      clr_w = 1'b0; randW = '0; ifm_bit = 4'hF; ifm_sign = 4'h0;

      // clear beats load
      wght = {4{16'h7FFF}}; en_w = 1'b1; clr_w = 1'b1; tick(); en_w = 1'b0; clr_w = 1'b0;
      chk("clr_over_en", wght_d0, 64'd0);

      // zero-length start is ignored
      cfg_len = '0; start = 1'b1; tick(); start = 1'b0;
      chk("len0_idle", 64'({busy0, busy1}), 64'd0);

      // unipolar full-scale window, with a start during RUN that must be ignored
      load_w({4{16'h7FFF}});
      ofm = 24'd1000;
      kick(8, 24'd1032, 24'd1032, 0);
      tick();
      chk("run_busy", 64'({busy0, busy1}), 64'b11);
      chk("run_pass", 64'(ofm_d0), 64'd1000);
      cfg_len = 16'd1; start = 1'b1; tick(); start = 1'b0;
      wait_done("uni32");

      // bipolar: lane0 at -max
      load_w(64'h0000_0000_0000_FFFF);
      ofm = 24'd100;
      kick(5, 24'd105, 24'd95, 0);
      wait_done("bi_neg");

      // mixed magnitudes against randW, including randW == |w|
      load_w(64'h7FFF_0100_0010_0000);
      randW = 15'h0080; ofm = 24'd0;
      kick(6, 24'd12, 24'd12, 0);
      wait_done("partial");
      randW = 15'h0100; ifm_bit = 4'b1100; ifm_sign = 4'b1000; ofm = 24'd50;
      kick(3, 24'd53, 24'd47, 0);
      wait_done("cmp_edge");

      // stall for 3 cycles
      load_w({4{16'h7FFF}});
      randW = '0; ifm_bit = 4'hF; ifm_sign = 4'h0; ofm = 24'd7;
      kick(4, 24'd23, 24'd23, 3);
      en_o = 1'b0; tick(); tick(); tick(); en_o = 1'b1;
      wait_done("stall");

      // abort on the last RUN cycle
      ofm = 24'd9; cfg_len = 16'd3; start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      clr_o = 1'b1; tick(); clr_o = 1'b0;
      chk("abort_idle", 64'({busy0, busy1, done0, done1}), 64'd0);
      chk("abort_pass", 64'(ofm_d0), 64'd9);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_nodone", 64'({done0, done1}), 64'd0);
      end
      kick(2, 24'd17, 24'd17, 0);
      wait_done("after_abort");

      // saturation both ways
      ofm = 24'h7FFFF6;
      kick(5, 24'h7FFFFF, 24'h7FFFFF, 0);
      wait_done("sat_pos");
      load_w({4{16'hFFFF}});
      ofm = 24'h80000A;
      kick(5, 24'h80001E, 24'h800000, 0);
      wait_done("sat_neg");

      // back-to-back: restart during DONE
      load_w({4{16'h7FFF}});
      ofm = 24'd0;
      kick(3, 24'd12, 24'd12, 0);
      tick(); tick(); tick();
      kick(2, 24'd8, 24'd8, 0);
      wait_done("b2b_first");
      wait_done("b2b_second");

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
